// File: rtl/vmcmp_pkg.sv
// rtl/vmcmp_pkg.sv - shared types and helpers for the mask-compare sequencer
package vmcmp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRITE} state_t;

  typedef enum logic [1:0] {SEW_8 = 2'd0, SEW_16 = 2'd1, SEW_32 = 2'd2, SEW_64 = 2'd3} sew_t;

  typedef enum logic [2:0] {
    OP_EQ = 3'd0, OP_NE = 3'd1, OP_LTU = 3'd2, OP_LT = 3'd3,
    OP_LEU = 3'd4, OP_LE = 3'd5, OP_GTU = 3'd6, OP_GT = 3'd7
  } opsel_t;

  localparam int unsigned MASK_WORD_BITS = 64;

  // Elements carried by one 64-bit operand beat for a given element width.
  function automatic logic [3:0] epb(input logic [1:0] sew);
    epb = 4'd8 >> sew;
  endfunction

endpackage

// File: rtl/vmcmp_seq_mask_word_acc.sv
// rtl/vmcmp_seq_mask_word_acc.sv - packs per-beat result bits into one 64-bit mask word
module mask_word_acc
  import vmcmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_acc_en,
  input  logic [63:0] i_vec,
  input  logic [1:0]  i_sew,
  input  logic [6:0]  i_nbits,
  output logic [63:0] o_mask,
  output logic [7:0]  o_be
);

  logic [63:0] r_mask;
  logic [6:0]  r_res_off;
  logic [3:0]  w_epb;
  logic [63:0] w_lane_mask;
  logic [63:0] w_valid_mask;
  logic [63:0] w_shifted;

  assign w_epb = epb(i_sew);

  // Keep only this beat's lanes, place them at res_off, and drop bits past vl.
  always_comb begin
    w_lane_mask  = (64'd1 << w_epb) - 64'd1;
    w_valid_mask = i_nbits[6] ? '1 : ((64'd1 << i_nbits[5:0]) - 64'd1);
    w_shifted    = ((i_vec & w_lane_mask) << r_res_off[5:0]) & w_valid_mask;
  end

  // Byte enables cover every byte holding at least one valid mask bit.
  always_comb begin
    o_be = '0;
    for (int k = 0; k < 8; k++) begin
      o_be[k] = (i_nbits > 7'(8 * k));
    end
  end

  // Accumulator: clear starts a fresh word, each returned beat ORs into place.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_mask    <= '0;
      r_res_off <= '0;
    end else if (i_acc_en) begin
      r_mask    <= r_mask | w_shifted;
      r_res_off <= r_res_off + {3'b000, w_epb};
    end
  end

  assign o_mask = r_mask;

endmodule

// File: rtl/vmcmp_seq.sv
// rtl/vmcmp_seq.sv - sequencer feeding the vector mask-compare unit and writing mask words
module vmcmp_seq
  import vmcmp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int VL_WIDTH   = 11,
  parameter int CMP_LAT    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VL_WIDTH-1:0]     cfg_vl,
  input  logic [1:0]              cfg_sew,
  input  logic [2:0]              cfg_opsel,
  input  logic [ADDR_WIDTH-1:0]   cfg_dest_addr,
  output logic                    busy,
  output logic                    done,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [DATA_WIDTH-1:0]   op_vec0,
  input  logic [DATA_WIDTH-1:0]   op_vec1,
  output logic                    cmp_valid,
  output logic [DATA_WIDTH-1:0]   cmp_vec0,
  output logic [DATA_WIDTH-1:0]   cmp_vec1,
  output logic [2:0]              cmp_sew,
  output logic [2:0]              cmp_opsel,
  output logic [2:0]              cmp_start_idx,
  output logic [ADDR_WIDTH-1:0]   cmp_addr,
  input  logic                    cmp_out_valid,
  input  logic [DATA_WIDTH-1:0]   cmp_out_vec,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [ADDR_WIDTH-1:0]   wb_addr,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic [DATA_WIDTH/8-1:0] wb_be
);

  localparam int IFW = $clog2(CMP_LAT + 1);
  localparam int TW  = VL_WIDTH + 1;
  localparam logic [TW-1:0]         WORD_ELEMS = TW'(MASK_WORD_BITS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(8);
  localparam logic [IFW-1:0]        IF_ONE     = IFW'(1);

  state_t                r_state;
  logic [VL_WIDTH-1:0]   r_vl;
  logic [1:0]            r_sew;
  logic [2:0]            r_opsel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TW-1:0]         r_issued_total;
  logic [TW-1:0]         r_word_base;
  logic [6:0]            r_word_issued;
  logic [IFW-1:0]        r_inflight;
  logic                  r_busy, r_done, r_cmp_valid, r_wb_valid;
  logic [DATA_WIDTH-1:0] r_cmp_vec0, r_cmp_vec1;

  logic [3:0]    w_epb;
  logic [TW-1:0] w_vl_ext, w_total_next, w_rem;
  logic [6:0]    w_word_next, w_nbits;
  logic          w_hs, w_ret, w_more, w_clear;

  assign w_epb        = epb(r_sew);
  assign w_vl_ext     = {1'b0, r_vl};
  assign w_total_next = r_issued_total + {{(TW-4){1'b0}}, w_epb};
  assign w_word_next  = r_word_issued + {3'b000, w_epb};
  assign w_more       = (r_issued_total < w_vl_ext);
  assign op_ready     = (r_state == RUN) && w_more && (r_word_issued < 7'd64);
  assign w_hs         = op_valid && op_ready;
  assign w_ret        = cmp_out_valid && (r_state != IDLE);
  assign w_rem        = w_vl_ext - r_word_base;
  assign w_nbits      = (w_rem >= WORD_ELEMS) ? 7'd64 : w_rem[6:0];
  assign w_clear      = ((r_state == IDLE) && start && (cfg_vl != '0)) ||
                        ((r_state == WRITE) && wb_ready && w_more);

  mask_word_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_acc_en (w_ret),
    .i_vec    (cmp_out_vec),
    .i_sew    (r_sew),
    .i_nbits  (w_nbits),
    .o_mask   (wb_data),
    .o_be     (wb_be)
  );

  // Control FSM plus the registered compare-unit and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_vl           <= '0;
      r_sew          <= '0;
      r_opsel        <= '0;
      r_addr         <= '0;
      r_issued_total <= '0;
      r_word_base    <= '0;
      r_word_issued  <= '0;
      r_inflight     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cmp_valid    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_cmp_vec0     <= '0;
      r_cmp_vec1     <= '0;
    end else begin
      r_done      <= 1'b0;
      r_cmp_valid <= w_hs;
      if (w_hs) begin
        r_cmp_vec0 <= op_vec0;
        r_cmp_vec1 <= op_vec1;
      end
      case ({r_cmp_valid, w_ret})
        2'b10:   r_inflight <= r_inflight + IF_ONE;
        2'b01:   r_inflight <= r_inflight - IF_ONE;
        default: r_inflight <= r_inflight;
      endcase
      case (r_state)
        IDLE: begin
          if (start) begin
            if (cfg_vl == '0) begin
              r_done <= 1'b1;
            end else begin
              r_vl           <= cfg_vl;
              r_sew          <= cfg_sew;
              r_opsel        <= cfg_opsel;
              r_addr         <= cfg_dest_addr;
              r_issued_total <= '0;
              r_word_base    <= '0;
              r_word_issued  <= '0;
              r_busy         <= 1'b1;
              r_state        <= RUN;
            end
          end
        end
        RUN: begin
          if (w_hs) begin
            r_issued_total <= w_total_next;
            r_word_issued  <= w_word_next;
            if ((w_word_next == 7'd64) || (w_total_next >= w_vl_ext)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final beat is still one register stage away while r_cmp_valid is high.
          if ((r_inflight == '0) && !r_cmp_valid) begin
            r_wb_valid <= 1'b1;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          if (wb_ready) begin
            r_wb_valid <= 1'b0;
            if (w_more) begin
              r_addr        <= r_addr + ADDR_STEP;
              r_word_issued <= '0;
              r_word_base   <= r_word_base + WORD_ELEMS;
              r_state       <= RUN;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign cmp_valid     = r_cmp_valid;
  assign cmp_vec0      = r_cmp_vec0;
  assign cmp_vec1      = r_cmp_vec1;
  assign cmp_sew       = {1'b0, r_sew};
  assign cmp_opsel     = r_opsel;
  assign cmp_start_idx = 3'd0;
  assign cmp_addr      = r_addr;
  assign wb_valid      = r_wb_valid;
  assign wb_addr       = r_addr;

endmodule

// File: tb/tb_vmcmp_seq.sv
// tb/tb_vmcmp_seq.sv - scoreboard bench for vmcmp_seq
module tb_vmcmp_seq;

  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int VW  = 11;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [VW-1:0] cfg_vl = '0;
  logic [1:0]    cfg_sew = '0;
  logic [2:0]    cfg_opsel = '0;
  logic [AW-1:0] cfg_dest_addr = '0;
  logic          busy, done;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_vec0, op_vec1;
  logic          cmp_valid;
  logic [DW-1:0] cmp_vec0, cmp_vec1;
  logic [2:0]    cmp_sew, cmp_opsel, cmp_start_idx;
  logic [AW-1:0] cmp_addr;
  logic          cmp_out_valid;
  logic [DW-1:0] cmp_out_vec;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [7:0]    wb_be;

  vmcmp_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VL_WIDTH(VW), .CMP_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_vl(cfg_vl), .cfg_sew(cfg_sew),
    .cfg_opsel(cfg_opsel), .cfg_dest_addr(cfg_dest_addr), .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready), .op_vec0(op_vec0), .op_vec1(op_vec1),
    .cmp_valid(cmp_valid), .cmp_vec0(cmp_vec0), .cmp_vec1(cmp_vec1), .cmp_sew(cmp_sew),
    .cmp_opsel(cmp_opsel), .cmp_start_idx(cmp_start_idx), .cmp_addr(cmp_addr),
    .cmp_out_valid(cmp_out_valid), .cmp_out_vec(cmp_out_vec),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; logic [7:0] be;} wr_t;
  typedef struct {logic [DW-1:0] v0; logic [DW-1:0] v1;} beat_t;
  typedef struct {logic v; logic [DW-1:0] r;} res_t;

  wr_t   exp_q[$];
  beat_t beat_q[$];
  res_t  pipe_q[$];
  logic [1:0] cur_sew = '0;
  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cmp_fn(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] sew, input logic [2:0] op);
    int w;
    int n;
    logic [63:0] ma, mb, msk;
    w = 8 << sew;
    n = 8 >> sew;
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    cmp_fn = '0;
    for (int i = 0; i < n; i++) begin
      ma = (a >> (i * w)) & msk;
      mb = (b >> (i * w)) & msk;
      cmp_fn[i] = (op == 3'd1) ? (ma != mb) : (ma == mb);
    end
  endfunction

  // Operand source: presents the head of beat_q, advances on handshake.
  initial begin : feed
    logic hs;
    op_valid = 1'b0;
    op_vec0  = '0;
    op_vec1  = '0;
    forever begin
      @(negedge clk);
      hs = op_valid && op_ready;
      @(posedge clk);
      #1;
      if (hs && beat_q.size() > 0) void'(beat_q.pop_front());
      if (beat_q.size() > 0) begin
        op_valid = 1'b1;
        op_vec0  = beat_q[0].v0;
        op_vec1  = beat_q[0].v1;
      end else begin
        op_valid = 1'b0;
      end
    end
  end

  // Compare unit model with a fixed LAT-cycle latency.
  initial begin : cmp_model
    res_t s;
    cmp_out_valid = 1'b0;
    cmp_out_vec   = '0;
    forever begin
      @(negedge clk);
      s.v = cmp_valid;
      s.r = cmp_fn(cmp_vec0, cmp_vec1, cmp_sew, cmp_opsel);
      pipe_q.push_back(s);
      @(posedge clk);
      #1;
      if (pipe_q.size() >= LAT) begin
        s = pipe_q.pop_front();
        cmp_out_valid = s.v;
        cmp_out_vec   = s.v ? s.r : '0;
      end
    end
  end

  // Monitor: scoreboard pops on each writeback handshake, plus hold/stall checks.
  initial begin : monitor
    wr_t e;
    logic prev_wait;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [7:0] pb;
    prev_wait = 1'b0;
    pa = '0;
    pd = '0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (prev_wait) begin
        check("wb_hold_valid", 64'(wb_valid), 64'd1);
        check("wb_hold_data", wb_data, pd);
        check("wb_hold_addr", 64'(wb_addr), 64'(pa));
        check("wb_hold_be", 64'(wb_be), 64'(pb));
      end
      if (wb_valid) check("op_ready_low_in_write", 64'(op_ready), 64'd0);
      if (cmp_valid) begin
        check("cmp_sew", 64'(cmp_sew), 64'({1'b0, cur_sew}));
        check("cmp_start_idx", 64'(cmp_start_idx), 64'd0);
      end
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL wb_unexpected: got write addr 0x%0h data 0x%0h, required none", wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 64'(wb_addr), 64'(e.addr));
          check("wb_data", wb_data, e.data);
          check("wb_be", 64'(wb_be), 64'(e.be));
        end
      end
      prev_wait = wb_valid && !wb_ready;
      pa = wb_addr;
      pd = wb_data;
      pb = wb_be;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [VW-1:0] vl, input logic [1:0] sew,
                        input logic [2:0] op, input logic [AW-1:0] addr);
    cfg_vl = vl;
    cfg_sew = sew;
    cfg_opsel = op;
    cfg_dest_addr = addr;
    cur_sew = sew;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    n_vec++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_done: got no done pulse in %0d cycles, required one", name, budget);
    end else begin
      check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    end
    cyc(1);
  endtask

  task automatic push_beats(input int n, input logic [63:0] v0, input logic [63:0] v1);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.v0 = v0;
      b.v1 = v1;
      beat_q.push_back(b);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] be);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.be = be;
    exp_q.push_back(w);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op_ready"}, 64'(op_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cmp_valid"}, 64'(cmp_valid), 64'd0);
    check({tag, "_cmp_vec0"}, cmp_vec0, 64'd0);
    check({tag, "_cmp_addr"}, 64'(cmp_addr), 64'd0);
    check({tag, "_cmp_opsel"}, 64'(cmp_opsel), 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_wb_addr"}, 64'(wb_addr), 64'd0);
    check({tag, "_wb_data"}, wb_data, 64'd0);
    check({tag, "_wb_be"}, 64'(wb_be), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic found;
    logic seen;
    cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    cyc(1);

    // vl=8, SEW8, EQ, equal operands: one byte of ones
    push_beats(1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    push_exp(32'h0000_1000, 64'h0000_0000_0000_00FF, 8'h01);
    launch(11'd8, 2'd0, 3'd0, 32'h0000_1000);
    wait_done("t1", 100);

    // vl=20, SEW32: lane0 equal, lane1 different; also a start while busy
    push_beats(10, {32'h2222_2222, 32'h1111_1111}, {32'h3333_3333, 32'h1111_1111});
    push_exp(32'h0000_2000, 64'h0000_0000_0005_5555, 8'h07);
    launch(11'd20, 2'd2, 3'd0, 32'h0000_2000);
    cyc(2);
    cfg_vl = 11'd8;
    cfg_sew = 2'd0;
    cfg_dest_addr = 32'h0000_9000;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done("t2", 200);

    // vl=100, SEW8, all equal: full word then 36-bit tail
    push_beats(13, 64'hA5A5_A5A5_5A5A_5A5A, 64'hA5A5_A5A5_5A5A_5A5A);
    push_exp(32'h0000_3000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    push_exp(32'h0000_3008, 64'h0000_000F_FFFF_FFFF, 8'h1F);
    launch(11'd100, 2'd0, 3'd0, 32'h0000_3000);
    wait_done("t3", 400);

    // vl=16, SEW16, NE, wb_ready held low for 5 cycles in WRITE
    push_beats(4, 64'h4444_3333_2222_1111, 64'h0000_3333_0000_1111);
    push_exp(32'h0000_4000, 64'h0000_0000_0000_AAAA, 8'h03);
    wb_ready = 1'b0;
    launch(11'd16, 2'd1, 3'd1, 32'h0000_4000);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      found = wb_valid;
    end
    check("t4_wb_valid_seen", 64'(found), 64'd1);
    cyc(5);
    wb_ready = 1'b1;
    wait_done("t4", 100);

    // vl=0: done the next cycle, no writeback
    launch(11'd0, 2'd0, 3'd0, 32'h0000_5000);
    @(negedge clk);
    check("t5_done", 64'(done), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_wb_valid", 64'(wb_valid), 64'd0);
    cyc(1);
    @(negedge clk);
    check("t5_done_one_cycle", 64'(done), 64'd0);
    cyc(1);

    // reset mid-RUN with beats in flight; late results must not write back
    push_beats(8, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
    launch(11'd64, 2'd0, 3'd0, 32'h0000_6000);
    cyc(4);
    rst = 1'b1;
    beat_q.delete();
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t6_after_rst");
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
    end
    check("t6_no_writeback", 64'(seen), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);

    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vmcmp_seq.md
# vmcmp_seq

Sequencer for the vector mask-compare unit. It accepts one mask-compare instruction (vl, SEW, opSel, destination address) and streams operand beats from the register-read port into the compare pipeline. The returned per-beat mask bits are packed into 64-bit mask words, and each finished word is written to the register file over a ready/valid writeback port. It sits between the vector issue/decode stage and the compare datapath, and stalls operand reads while a mask word drains.

## Interface
- DATA_WIDTH, 64, operand/mask word width (only 64 supported)
- ADDR_WIDTH, 32, register-file address width
- VL_WIDTH, 11, width of vl (max 2^VL_WIDTH-1 elements)
- CMP_LAT, 6, fixed compare-unit latency, cmp_valid to cmp_out_valid

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch instruction; sampled only in IDLE
- cfg_vl  in  VL_WIDTH  element count
- cfg_sew  in  2  0=8b, 1=16b, 2=32b, 3=64b
- cfg_opsel  in  3  compare op, passed through
- cfg_dest_addr  in  ADDR_WIDTH  address of first mask word
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- op_valid  in  1  operand beat available
- op_ready  out  1  beat accepted when op_valid&op_ready
- op_vec0, op_vec1  in  DATA_WIDTH  operand beat
- cmp_valid  out  1  beat to compare unit
- cmp_vec0, cmp_vec1  out  DATA_WIDTH  registered operands
- cmp_sew  out  3  {0,sew}
- cmp_opsel  out  3  latched opSel
- cmp_start_idx  out  3  constant 0; the sequencer does the packing
- cmp_addr  out  ADDR_WIDTH  current mask-word address
- cmp_out_valid  in  1  result beat
- cmp_out_vec  in  DATA_WIDTH  result bits [epb-1:0]
- wb_valid, wb_ready  out/in  1  writeback handshake
- wb_addr  out  ADDR_WIDTH  mask-word address
- wb_data  out  DATA_WIDTH  mask word
- wb_be  out  DATA_WIDTH/8  byte enables

## Operation
- Elements per beat: epb = 8>>sew. Word capacity is 64 elements, i.e. 64/epb beats.
- States:
  - IDLE
    - start with vl>0: latch cfg, then RUN.
    - start with vl=0: done pulse, stay IDLE.
  - RUN
    - op_ready = (issued_total < vl) & (word_issued < 64).
    - Each handshake adds epb to both counters and is forwarded to the compare unit.
    - When word_issued hits 64 or issued_total ≥ vl, go to DRAIN.
  - DRAIN: wait until inflight==0 and the last result has been accumulated, then WRITE.
  - WRITE: hold wb_valid with stable data.
    - On wb_ready with elements remaining: clear the accumulator, add 8 to the address, clear word_issued, go to RUN.
    - Otherwise: done pulse, go to IDLE.
- Accumulation: results return in order. mask |= (cmp_out_vec & lane_mask) << res_off, then res_off += epb.
  - lane_mask clears bits whose element index is ≥ vl.
  - Tail bits above vl in the word are 0.
- wb_be: set for bytes 0..ceil(nbits/8)-1, where nbits = valid mask bits in the word.
- inflight: +1 on cmp_valid, −1 on cmp_out_valid, both allowed in the same cycle. Width is clog2(CMP_LAT+1).
- cmp_out_valid in IDLE is ignored.
- start while busy is ignored.

## Timing
- Reset values: every output 0 (op_ready, busy, done, cmp_valid, wb_valid, all data/addr/be). State IDLE, counters 0.
- cmp_* is registered: cmp_valid is asserted the cycle after an op handshake.
- Full-word stall: op_ready drops the cycle after the 64th bit's beat is accepted. It stays low through DRAIN and WRITE, at least CMP_LAT+1 cycles.
- Minimum instruction time: 1 (start) + beats + CMP_LAT + 1 (WRITE) per word.
- done goes high in the cycle after the final wb handshake, or the cycle after start when vl=0. busy falls in that same cycle.
- rst mid-operation: everything returns to IDLE within one cycle. Partial mask is discarded, no writeback.

## Structure
- Shared package vmcmp_pkg:
  - state enum {IDLE, RUN, DRAIN, WRITE}
  - SEW encodings
  - opSel encodings (EQ, NE, LTU, LT, LEU, LE, GTU, GT)
  - function epb(sew)
- Sub-module mask_word_acc: 64-bit accumulator with res_off, lane masking, clear, and nbits→wb_be generation.

## Test plan
- vl=8, sew=0, vmseq, equal operands → one write: wb_data=0x00000000000000FF, wb_be=0x01, wb_addr=A; done follows.
- vl=20, sew=2, lanes alternate equal/unequal → 10 beats; wb_data bits[19:0]=0x55555, upper bits 0, wb_be=0x07.
- vl=100, sew=0, all true → two writes.
  - First: addr A, data all-ones, be 0xFF.
  - Second: addr A+8, data 0x0000000FFFFFFFFF, be 0x1F.
  - op_ready is low between the two words.
- Hold wb_ready low 5 cycles in WRITE → wb_valid, data, addr stable; op_ready stays 0; no lost or duplicated write.
- start with vl=0 → done at the next cycle, wb_valid never asserted; a start while busy is ignored.
- rst asserted mid-RUN with 3 beats in flight → next cycle all outputs 0; late cmp_out_valid pulses cause no writeback.
